bcd_serial_addsub: RTL and testbench
====================================

BCD_SERIAL_ADDSUB -- requirements
Module: bcd_serial_addsub

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of packed BCD digits per operand (legal range 1..16).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-004 SHALL have port start  input  1  operation request, sampled only in IDLE.
REQ-005 SHALL have port sub  input  1  mode: 0 = a+b+cin, 1 = a-b-cin.
REQ-006 SHALL have port cin  input  1  carry-in (add) or borrow-in (sub).
REQ-007 SHALL have port a  input  4*DIGITS  packed BCD operand, digit 0 (least significant) in [3:0].
REQ-008 SHALL have port b  input  4*DIGITS  packed BCD operand, same packing as a.
REQ-009 SHALL have port busy  output  1  high while digits are being processed (RUN).
REQ-010 SHALL have port done  output  1  single-cycle completion pulse.
REQ-011 SHALL have port result  output  4*DIGITS  packed BCD result of the last completed operation.
REQ-012 SHALL have port cout  output  1  carry-out (add) or borrow-out (sub) of the last completed operation.
REQ-013 SHALL have port invalid  output  1  any digit of the captured a or b was greater than 9 in the last completed operation.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-015 IDLE with start=1: SHALL capture a, b, sub, cin into working registers, clear digit index to 0, enter RUN.
REQ-016 IDLE with start=0: SHALL remain in IDLE.
REQ-017 RUN SHALL process exactly one digit per cycle, digit k in the k-th RUN cycle, k = 0..DIGITS-1; captured operands, not live inputs, are used.
REQ-018 Digit step, add: s = a_k + b_k + c (5-bit); if s > 9, digit = s-10 and c = 1, else digit = s and c = 0.
REQ-019 Digit step, sub: identical step using (9 - b_k) in place of b_k; initial c = ~cin; final borrow = ~c.
REQ-020 Initial c for add SHALL be cin.
REQ-021 After digit DIGITS-1, SHALL enter DONE; DONE lasts exactly one cycle, then returns to IDLE.
REQ-022 In DONE, SHALL update result, cout and invalid together, and SHALL assert done=1.
REQ-023 result, cout and invalid SHALL hold their values from DONE until the next DONE; they SHALL NOT change during RUN.
REQ-024 Latency: start sampled at edge T SHALL produce done=1 in the cycle following edge T+DIGITS+1; busy=1 for exactly DIGITS cycles.
REQ-025 Sub with a < b+cin SHALL wrap modulo 10^DIGITS (ten's complement) and set cout=1; add overflow SHALL wrap modulo 10^DIGITS and set cout=1.
REQ-026 invalid SHALL be the OR over all captured a and b digits of (digit > 9); result and cout are unspecified when invalid=1.
REQ-027 start while in RUN or DONE SHALL be ignored and not queued; changes on a, b, sub or cin after capture SHALL NOT affect the operation.
REQ-028 DIGITS=1 SHALL work: one RUN cycle, then DONE.

Reset
REQ-029 rst_n=0 SHALL immediately force the FSM to IDLE and busy=0, done=0, result=0, cout=0, invalid=0, without waiting for clk.
REQ-030 Reset during RUN SHALL abandon the operation; no done pulse is produced for it.
REQ-031 After rst_n deasserts, start SHALL be accepted at the first rising edge.

Verification (DIGITS=4)
REQ-032 add a=1234 b=8766 cin=0 -> result=0000, cout=1, invalid=0, done in the cycle following edge T+5.
REQ-033 add a=0999 b=0001 cin=1 -> result=1001, cout=0.
REQ-034 sub a=5000 b=1234 cin=0 -> result=3766, cout=0; sub a=0123 b=0124 cin=0 -> result=9999, cout=1.
REQ-035 add a=0x12A4 b=0000 -> invalid=1; following valid add 0001+0001 -> result=0002, invalid=0.
REQ-036 start pulsed on each of the 4 RUN cycles with different operands -> only the first operation completes, single done pulse; busy high exactly 4 cycles.
REQ-037 rst_n pulsed low in the 2nd RUN cycle -> busy, done, result, cout, invalid all 0 immediately; no done pulse; next start computes correctly.

Source files
------------

// File: rtl/bcd_serial_addsub.sv
// -----------------------------------------------------------------------------
// bcd_serial_addsub
//   Digit-serial packed-BCD adder/subtractor. One decimal digit is processed
//   per clock, least significant first. Subtraction uses the nines'-complement
//   of b with an inverted carry chain, so both modes share one digit adder.
//
// Ports
//   clk      : sole clock, rising edge
//   rst_n    : asynchronous active-low reset
//   start    : operation request, sampled only in IDLE
//   sub      : 0 = a+b+cin, 1 = a-b-cin
//   cin      : carry-in (add) / borrow-in (sub)
//   a, b     : packed BCD operands, digit 0 in [3:0]
//   busy     : high while digits are being processed
//   done     : one-cycle pulse when result/cout/invalid are updated
//   result   : packed BCD result of the last completed operation
//   cout     : carry-out (add) / borrow-out (sub) of the last operation
//   invalid  : a captured digit of a or b was > 9 in the last operation
// -----------------------------------------------------------------------------
module bcd_serial_addsub #(
  parameter int DIGITS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              sub,
  input  logic              cin,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [4*DIGITS-1:0] result,
  output logic              cout,
  output logic              invalid
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [W-1:0]       a_q, a_d;       // shifts right one digit per RUN cycle
  logic [W-1:0]       b_q, b_d;
  logic [W-1:0]       acc_q, acc_d;   // result digits shift in from the top
  logic               sub_q, sub_d;
  logic               c_q, c_d;
  logic               inv_q, inv_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [W-1:0]       result_q, result_d;
  logic               cout_q, cout_d;
  logic               invalid_q, invalid_d;
  logic               done_q, done_d;

  // Digit step on the current least significant working digit.
  logic [3:0] a_k, b_k, b_eff;
  logic [4:0] sum_s;
  logic [3:0] digit_s;
  logic       carry_s;
  logic       digit_bad;

  always_comb begin
    a_k       = a_q[3:0];
    b_k       = b_q[3:0];
    b_eff     = sub_q ? (4'd9 - b_k) : b_k;
    sum_s     = {1'b0, a_k} + {1'b0, b_eff} + {4'b0000, c_q};
    carry_s   = (sum_s > 5'd9);
    // s-10 and s+6 agree modulo 16, so the low nibble is the corrected digit.
    digit_s   = carry_s ? (sum_s[3:0] + 4'd6) : sum_s[3:0];
    digit_bad = (a_k > 4'd9) || (b_k > 4'd9);
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    sub_d     = sub_q;
    c_d       = c_q;
    inv_d     = inv_q;
    idx_d     = idx_q;
    result_d  = result_q;
    cout_d    = cout_q;
    invalid_d = invalid_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sub_d   = sub;
          c_d     = sub ? ~cin : cin;
          inv_d   = 1'b0;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q >> 4;
        b_d   = b_q >> 4;
        acc_d = W'({digit_s, acc_q} >> 4);
        c_d   = carry_s;
        inv_d = inv_q | digit_bad;
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(DIGITS - 1)) state_d = DONE;
      end
      DONE: begin
        // Visible outputs change only here, all in the same edge as done.
        result_d  = acc_q;
        cout_d    = sub_q ? ~c_q : c_q;
        invalid_d = inv_q;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      sub_q     <= 1'b0;
      c_q       <= 1'b0;
      inv_q     <= 1'b0;
      idx_q     <= '0;
      result_q  <= '0;
      cout_q    <= 1'b0;
      invalid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      sub_q     <= sub_d;
      c_q       <= c_d;
      inv_q     <= inv_d;
      idx_q     <= idx_d;
      result_q  <= result_d;
      cout_q    <= cout_d;
      invalid_q <= invalid_d;
      done_q    <= done_d;
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = done_q;
  assign result  = result_q;
  assign cout    = cout_q;
  assign invalid = invalid_q;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// -----------------------------------------------------------------------------
// tb_bcd_serial_addsub
//   Directed and random operations on a DIGITS=4 instance, checked against a
//   decimal-arithmetic reference model (integers modulo 10^4).
// -----------------------------------------------------------------------------
module tb_bcd_serial_addsub;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;
  localparam int MODV   = 10000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, cout, invalid;
  logic [W-1:0] result;

  int checks = 0;
  int failures = 0;

  // Outputs the bench believes the DUT currently holds.
  logic [W-1:0] held_result = '0;
  logic         held_cout = 1'b0;
  logic         held_invalid = 1'b0;

  bcd_serial_addsub #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .cin(cin),
    .a(a), .b(b), .busy(busy), .done(done), .result(result),
    .cout(cout), .invalid(invalid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic has_bad(input logic [W-1:0] v);
    for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] r;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  task automatic scramble_inputs();
    a   = W'($urandom);
    b   = W'($urandom);
    sub = 1'($urandom);
    cin = 1'($urandom);
  endtask

  // Issue one operation and follow it for 8 samples taken 1ns after each edge.
  task automatic do_op(input string tag, input logic [W-1:0] aa, input logic [W-1:0] bb,
                       input logic s, input logic c, input bit hammer);
    int av, bv, tot;
    logic [W-1:0] exp_res;
    logic exp_cout, exp_inv, stable;
    int busy_cnt, done_cnt, done_at;

    av = bcd2int(aa);
    bv = bcd2int(bb);
    exp_inv = has_bad(aa) || has_bad(bb);
    if (!s) begin
      tot = av + bv + int'(c);
      exp_cout = (tot >= MODV);
      tot = tot % MODV;
    end else begin
      tot = av - bv - int'(c);
      exp_cout = (tot < 0);
      if (tot < 0) tot += MODV;
    end
    exp_res = int2bcd(tot);

    @(negedge clk);
    a = aa; b = bb; sub = s; cin = c; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    scramble_inputs();
    busy_cnt = 0; done_cnt = 0; done_at = -1; stable = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (k <= 4 && (result !== held_result || cout !== held_cout || invalid !== held_invalid))
        stable = 1'b0;
      if (hammer && k < 4) begin
        start = 1'b1;
        scramble_inputs();
      end else begin
        start = 1'b0;
      end
    end
    check({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(DIGITS));
    check({tag, ".done_latency"}, 64'(done_at), 64'(DIGITS + 1));
    check({tag, ".done_count"}, 64'(done_cnt), 64'd1);
    check({tag, ".held_in_run"}, 64'(stable), 64'd1);
    check({tag, ".invalid"}, 64'(invalid), 64'(exp_inv));
    if (!exp_inv) begin
      check({tag, ".result"}, 64'(result), 64'(exp_res));
      check({tag, ".cout"}, 64'(cout), 64'(exp_cout));
    end
    held_result  = result;
    held_cout    = cout;
    held_invalid = invalid;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".busy"}, 64'(busy), 64'd0);
    check({tag, ".done"}, 64'(done), 64'd0);
    check({tag, ".result"}, 64'(result), 64'd0);
    check({tag, ".cout"}, 64'(cout), 64'd0);
    check({tag, ".invalid"}, 64'(invalid), 64'd0);
  endtask

  initial begin
    int done_seen;

    // Power-on reset.
    #2;
    check_reset_outputs("por");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Directed cases.
    do_op("add_1234_8766", 16'h1234, 16'h8766, 1'b0, 1'b0, 1'b0);
    do_op("add_0999_0001_c", 16'h0999, 16'h0001, 1'b0, 1'b1, 1'b0);
    do_op("sub_5000_1234", 16'h5000, 16'h1234, 1'b1, 1'b0, 1'b0);
    do_op("sub_0123_0124", 16'h0123, 16'h0124, 1'b1, 1'b0, 1'b0);
    do_op("sub_0000_0000_b", 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0);
    do_op("add_9999_9999_c", 16'h9999, 16'h9999, 1'b0, 1'b1, 1'b0);
    do_op("add_invalid", 16'h12A4, 16'h0000, 1'b0, 1'b0, 1'b0);
    do_op("add_after_inv", 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0);
    do_op("b_invalid", 16'h0000, 16'hF000, 1'b1, 1'b0, 1'b0);
    do_op("hammer", 16'h4321, 16'h1111, 1'b1, 1'b1, 1'b1);

    // Reset in the second RUN cycle abandons the operation.
    @(negedge clk);
    a = 16'h2222; b = 16'h3333; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    held_result = '0; held_cout = 1'b0; held_invalid = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    #1 rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    check("mid_reset.no_done", 64'(done_seen), 64'd0);

    // Start offered right at the first edge after reset release.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    do_op("post_reset", 16'h0456, 16'h0789, 1'b0, 1'b0, 1'b0);

    // Random valid operations.
    for (int i = 0; i < 12; i++)
      do_op($sformatf("rand%0d", i), rand_bcd(), rand_bcd(), 1'($urandom), 1'($urandom), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
